// File: rtl/glb_pkg.sv
// Shared global-buffer constants and payload types used by the GLB memory and its clients.
package glb_pkg;

  localparam int unsigned GLB_BYTES  = 65536;
  localparam int unsigned GLB_WORDS  = 16384;
  localparam int unsigned GLB_IDX_W  = 14;
  localparam int unsigned GLB_DATA_W = 32;

  typedef logic [GLB_DATA_W-1:0]   glb_word_t;
  typedef logic [GLB_DATA_W/8-1:0] glb_web_t;

endpackage : glb_pkg

// File: rtl/sram_64kb.sv
// 64 KB single-port global buffer: 32-bit words, active-low byte write enables,
// read-first registered read port. Storage is not cleared by reset so preloaded images survive.
module sram_64kb
  import glb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = GLB_DATA_W,
  parameter int unsigned DEPTH      = GLB_WORDS,
  parameter int unsigned IDX_WIDTH  = GLB_IDX_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH/8-1:0] WEB,
  input  logic [31:0]             addr,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic [DATA_WIDTH-1:0]   read_data
);

  localparam int unsigned LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] memory [0:DEPTH-1];
  logic [IDX_WIDTH-1:0]  idx;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  unused_addr;

  // Byte offset and bits above 64 KB are don't-care; addresses alias modulo the buffer size.
  assign idx         = addr[IDX_WIDTH+1:2];
  assign unused_addr = ^{addr[31:IDX_WIDTH+2], addr[1:0]};
  assign rdata_d     = memory[idx];

  // Lane writes; a non-zero (or unknown) enable bit leaves that lane untouched.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (!WEB[i]) begin
          memory[idx][8*i +: 8] <= write_data[8*i +: 8];
        end
      end
    end
  end

  // Read register samples the pre-write word, giving read-first collision behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign read_data = rdata_q;

endmodule : sram_64kb

// File: tb/tb_sram_64kb.sv
// Directed self-checking bench for the 64 KB global buffer memory.
module tb_sram_64kb;
  import glb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  WEB;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  int checks;
  int errors;

  sram_64kb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .WEB        (WEB),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic [3:0] web, input logic [31:0] a, input logic [31:0] wd);
    WEB        = web;
    addr       = a;
    write_data = wd;
    step();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    WEB        = 4'hF;
    addr       = 32'h0;
    write_data = 32'h0;
    dut.memory[0]         = 32'hDEADBEEF;
    dut.memory[14'h0400]  = 32'hAABBCCDD;
    #1;
    check("reset_t0", read_data, 32'h0);
    step();
    check("reset_cyc1", read_data, 32'h0);
    step();
    check("reset_cyc2", read_data, 32'h0);

    rst_n = 1'b1;
    access(4'hF, 32'h0, 32'h0);
    check("preload_read", read_data, 32'hDEADBEEF);

    access(4'h0, 32'h1000, 32'h12345678);
    check("full_write_readfirst", read_data, 32'hAABBCCDD);
    access(4'hF, 32'h1000, 32'h0);
    check("full_readback", read_data, 32'h12345678);

    access(4'h0, 32'h1000, 32'hAABBCCDD);
    check("mask_setup_readfirst", read_data, 32'h12345678);
    access(4'b1010, 32'h1000, 32'h11223344);
    check("mask_write_readfirst", read_data, 32'hAABBCCDD);
    access(4'hF, 32'h1000, 32'h0);
    check("byte_mask_readback", read_data, 32'hAA22CC44);

    access(4'h0, 32'h3000, 32'h0);
    access(4'h0, 32'h3000, 32'hFFFFFFFF);
    check("collision_old", read_data, 32'h0);
    access(4'hF, 32'h3000, 32'h0);
    check("collision_new", read_data, 32'hFFFFFFFF);

    access(4'h0, 32'h0000_4000, 32'hCAFEF00D);
    access(4'hF, 32'h0001_4003, 32'h0);
    check("alias_align", read_data, 32'hCAFEF00D);
    access(4'hF, 32'hFFFF_0002, 32'h0);
    check("alias_high_word0", read_data, 32'hDEADBEEF);

    access(4'h0, 32'h2000, 32'h5A5A5A5A);
    access(4'hF, 32'h2000, 32'h0);
    check("midrst_setup", read_data, 32'h5A5A5A5A);

    // Write presented, then reset lands before the capturing edge.
    WEB        = 4'h0;
    addr       = 32'h2000;
    write_data = 32'hDEAD0000;
    rst_n      = 1'b0;
    #1;
    check("midrst_async_clear", read_data, 32'h0);
    step();
    check("midrst_hold1", read_data, 32'h0);
    step();
    check("midrst_hold2", read_data, 32'h0);

    WEB   = 4'hF;
    rst_n = 1'b1;
    step();
    check("midrst_word_kept", read_data, 32'h5A5A5A5A);
    access(4'hF, 32'h3000, 32'h0);
    check("post_reset_other", read_data, 32'hFFFFFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sram_64kb
